alu_exec_stage: RTL and testbench

//  Registered execute stage that consumes the 4-bit ALU control code from the ALU control unit
//  and the two operands, and produces Result/Zero/Overflow for the memory/writeback stage.

---
 rtl/alu_exec_if.sv | 27 ++
 rtl/alu_exec_stage.sv | 154 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Valid/ready bundle between the ALU control/operand source and the execute stage,
// and between the execute stage and memory/writeback.
interface alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUControlInput;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Zero;
   logic             Overflow;
   logic             Illegal;

   modport master (
      output in_valid, ALUControlInput, A, B, out_ready,
      input  in_ready, out_valid, Result, Zero, Overflow, Illegal
   );

   modport slave (
      input  in_valid, ALUControlInput, A, B, out_ready,
      output in_ready, out_valid, Result, Zero, Overflow, Illegal
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one output register plus one skid register, so in_ready
// is a flop and never combinationally depends on out_ready.
//
//   state | meaning
//   EMPTY | nothing held; out_valid=0
//   ONE   | output register holds the oldest op
//   TWO   | output register and skid register both full; in_ready=0
module alu_exec_stage #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   alu_exec_if.slave bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             in_ready_q;
   logic             in_fire;
   logic             out_fire;
   logic             load_out_in;
   logic             load_out_skid;
   logic             load_skid;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] calc_res;
   logic             calc_ovf;
   logic             calc_ill;
   logic             calc_zero;

   logic [WIDTH-1:0] out_res_q;
   logic             out_zero_q;
   logic             out_ovf_q;
   logic             out_ill_q;
   logic [WIDTH-1:0] skid_res_q;
   logic             skid_zero_q;
   logic             skid_ovf_q;
   logic             skid_ill_q;

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = (state_q != EMPTY) & bus.out_ready;

   assign sum  = bus.A + bus.B;
   assign diff = bus.A - bus.B;

   always_comb begin
      calc_res = '0;
      calc_ovf = 1'b0;
      calc_ill = 1'b0;
      case (bus.ALUControlInput)
         4'b0000: calc_res = bus.A & bus.B;
         4'b0001: calc_res = bus.A | bus.B;
         4'b0010: begin
            calc_res = sum;
            calc_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         4'b0110: begin
            calc_res = diff;
            calc_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         4'b0111: calc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         4'b1100: calc_res = ~(bus.A | bus.B);
         default: calc_ill = 1'b1;
      endcase
   end

   assign calc_zero = (calc_res == '0);

   always_comb begin
      state_d       = state_q;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d     = ONE;
               load_out_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_out_in = 1'b1;
            end else if (in_fire) begin
               state_d   = TWO;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_d       = ONE;
               load_out_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_res_q   <= '0;
         out_zero_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_ill_q   <= 1'b0;
         skid_res_q  <= '0;
         skid_zero_q <= 1'b0;
         skid_ovf_q  <= 1'b0;
         skid_ill_q  <= 1'b0;
      end else begin
         if (load_out_in) begin
            out_res_q  <= calc_res;
            out_zero_q <= calc_zero;
            out_ovf_q  <= calc_ovf;
            out_ill_q  <= calc_ill;
         end else if (load_out_skid) begin
            out_res_q  <= skid_res_q;
            out_zero_q <= skid_zero_q;
            out_ovf_q  <= skid_ovf_q;
            out_ill_q  <= skid_ill_q;
         end
         if (load_skid) begin
            skid_res_q  <= calc_res;
            skid_zero_q <= calc_zero;
            skid_ovf_q  <= calc_ovf;
            skid_ill_q  <= calc_ill;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.Result    = out_res_q;
   assign bus.Zero      = out_zero_q;
   assign bus.Overflow  = out_ovf_q;
   assign bus.Illegal   = out_ill_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based reference of the stage's contents.
module tb_alu_exec_stage;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
      logic         ovf;
      logic         ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t q[$];

   alu_exec_if #(.WIDTH(W)) bus ();

   alu_exec_stage #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference computed with wide signed arithmetic rather than sign-bit rules.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa;
      longint sb;
      longint t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e  = '0;
      case (op)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2: begin
            t = sa + sb;
            e.res = t[W-1:0];
            e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'd6: begin
            t = sa - sb;
            e.res = t[W-1:0];
            e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd12: e.res = ~(a | b);
         default: e.ill = 1'b1;
      endcase
      e.zero = (e.res == 0);
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit inf;
      bit outf;
      if (!rst_n) begin
         q.delete();
      end else begin
         inf  = bus.in_valid && (q.size() < 2);
         outf = (q.size() > 0) && bus.out_ready;
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(model(bus.ALUControlInput, bus.A, bus.B));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
         check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
         if (q.size() > 0) begin
            check("result", bus.Result, q[0].res);
            check("zero", {31'd0, bus.Zero}, {31'd0, q[0].zero});
            check("overflow", {31'd0, bus.Overflow}, {31'd0, q[0].ovf});
            check("illegal", {31'd0, bus.Illegal}, {31'd0, q[0].ill});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.in_valid        = 1'b1;
      bus.ALUControlInput = op;
      bus.A               = a;
      bus.B               = b;
   endtask

   task automatic pin(input string name, input logic [W-1:0] r, input logic z, input logic o, input logic i);
      check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({name, "_res"}, bus.Result, r);
      check({name, "_zero"}, {31'd0, bus.Zero}, {31'd0, z});
      check({name, "_ovf"}, {31'd0, bus.Overflow}, {31'd0, o});
      check({name, "_ill"}, {31'd0, bus.Illegal}, {31'd0, i});
   endtask

   initial begin
      logic [3:0] ops[7];
      exp_t       m;
      checks = 0;
      errors = 0;
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15};
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.ALUControlInput = 4'd0;
      bus.A = '0;
      bus.B = '0;
      bus.out_ready = 1'b0;

      m = model(4'd2, 32'd5, 32'd7);
      check("model_add", m.res, 32'd12);
      m = model(4'd6, 32'h8000_0000, 32'd1);
      check("model_sub_ovf", {31'd0, m.ovf}, 32'd1);
      m = model(4'd7, 32'hFFFF_FFFE, 32'd3);
      check("model_slt", m.res, 32'd1);
      m = model(4'd12, 32'h0F0F_0000, 32'h0000_00FF);
      check("model_nor", m.res, 32'hF0F0_FF00);

      #12;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_result", bus.Result, 32'd0);
      check("rst_flags", {29'd0, bus.Zero, bus.Overflow, bus.Illegal}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      bus.out_ready = 1'b1;
      put(4'd2, 32'd5, 32'd7);
      cyc();
      pin("add5_7", 32'd12, 1'b0, 1'b0, 1'b0);
      put(4'd6, 32'd9, 32'd9);
      cyc();
      pin("sub9_9", 32'd0, 1'b1, 1'b0, 1'b0);
      put(4'd2, 32'h7FFF_FFFF, 32'd1);
      cyc();
      pin("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      put(4'd6, 32'h8000_0000, 32'd1);
      cyc();
      pin("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      bus.in_valid = 1'b0;
      cyc();

      bus.out_ready = 1'b0;
      put(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
      cyc();
      put(4'd1, 32'h0000_F0F0, 32'h0000_FF00);
      cyc();
      check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      put(4'd7, 32'hFFFF_FFFF, 32'd1);
      cyc();
      check("bp_ignored_in_ready", {31'd0, bus.in_ready}, 32'd0);
      pin("bp_and_held", 32'h0000_F000, 1'b0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      cyc();
      pin("bp_or", 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
      cyc();
      pin("bp_slt", 32'd1, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      cyc();
      check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

      put(4'b1111, 32'd3, 32'd4);
      cyc();
      pin("illegal", 32'd0, 1'b1, 1'b0, 1'b1);
      put(4'd2, 32'd1, 32'd1);
      cyc();
      pin("illegal_cleared", 32'd2, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      cyc();

      bus.out_ready = 1'b0;
      put(4'd2, 32'd1, 32'd2);
      cyc();
      put(4'd1, 32'd4, 32'd8);
      cyc();
      bus.in_valid = 1'b0;
      check("two_in_ready", {31'd0, bus.in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("arst_result", bus.Result, 32'd0);
      cyc();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      check("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
      cyc();
      check("post_rst_no_stale2", {31'd0, bus.out_valid}, 32'd0);

      for (int n = 0; n < 1500; n++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: a = 32'h7FFF_FFFF;
            1: b = 32'h8000_0000;
            2: b = a;
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         bus.in_valid        = ($urandom_range(0, 9) < 7);
         bus.out_ready       = ($urandom_range(0, 9) < 6);
         bus.ALUControlInput = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : ops[$urandom_range(0, 6)];
         bus.A               = a;
         bus.B               = b;
         cyc();
      end

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) cyc();
      check("final_drained", {31'd0, bus.out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
